// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// Restoring divider, parallel multiplier committed after MUL_CYCLES.
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        hilo_rd,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_req,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  localparam logic [4:0] MUL_INIT = 5'(MUL_CYCLES - 1);

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_rem;
  logic        r_sa;
  logic        r_sb;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  logic        w_sdiv;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic        w_mul_s;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  logic [32:0] w_sh;
  logic [32:0] w_diff;
  logic        w_qb;
  logic [31:0] w_rem_nx;
  logic [31:0] w_q;
  logic [31:0] w_r;

  // Operand magnitudes for signed divide; 0x80000000 stays as-is.
  assign w_sdiv  = (op == 2'b10);
  assign w_abs_a = (w_sdiv & src_a[31]) ? -src_a : src_a;
  assign w_abs_b = (w_sdiv & src_b[31]) ? -src_b : src_b;

  // Sign-extend for MULT, zero-extend for MULTU; low 64 bits are exact.
  assign w_mul_s = ~r_op[0];
  assign w_ext_a = {{32{w_mul_s & r_a[31]}}, r_a};
  assign w_ext_b = {{32{w_mul_s & r_b[31]}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // One restoring step: shift in next dividend bit, trial subtract.
  assign w_sh     = {r_rem, r_a[31]};
  assign w_diff   = w_sh - {1'b0, r_b};
  assign w_qb     = ~w_diff[32];
  assign w_rem_nx = w_qb ? w_diff[31:0] : w_sh[31:0];

  // Sign fix-up; sign bits are zero for DIVU.
  assign w_q = (r_sa ^ r_sb) ? -r_a : r_a;
  assign w_r = r_sa ? -r_rem : r_rem;

  assign hi        = r_hi;
  assign lo        = r_lo;
  assign done      = r_done;
  assign busy      = (r_state != S_IDLE);
  assign stall_req = busy & (start | hilo_rd | hi_we | lo_we);

  // Sequencer, operand latches and HI/LO commit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (cancel) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
            if (start) begin
              r_op  <= op;
              r_rem <= '0;
              r_sa  <= w_sdiv & src_a[31];
              r_sb  <= w_sdiv & src_b[31];
              if (!op[1]) begin
                r_state <= S_MUL;
                r_cnt   <= MUL_INIT;
                r_a     <= src_a;
                r_b     <= src_b;
              end else if (src_b == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state <= S_DIV;
                r_cnt   <= 5'd31;
                r_a     <= w_abs_a;
                r_b     <= w_abs_b;
              end
            end
          end
          S_MUL: begin
            if (r_cnt == '0) begin
              r_hi    <= w_prod[63:32];
              r_lo    <= w_prod[31:0];
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - 5'd1;
            end
          end
          S_DIV: begin
            r_a   <= {r_a[30:0], w_qb};
            r_rem <= w_rem_nx;
            if (r_cnt == '0) begin
              r_state <= S_FIX;
            end else begin
              r_cnt <= r_cnt - 5'd1;
            end
          end
          S_FIX: begin
            r_lo    <= w_q;
            r_hi    <= w_r;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed cases with literal results,
// then random traffic against a cycle-count reference model.
module tb_muldiv_ctrl;

  localparam int MC = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        hilo_rd;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_req;
  logic        done;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_CYCLES(MC)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .cancel(cancel),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hilo_rd(hilo_rd), .hi(hi), .lo(lo), .busy(busy),
    .stall_req(stall_req), .done(done)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of an operation from plain arithmetic.
  function automatic logic [63:0] ref_res(input logic [1:0] o,
      input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: p = sa * sb;
      2'b01: p = ua * ub;
      2'b10: begin
        q = sa / sb;
        r = sa % sb;
        p = {r[31:0], q[31:0]};
      end
      default: p = {32'(ua % ub), 32'(ua / ub)};
    endcase
    return p;
  endfunction

  // Reference model: cycles-left counter plus pending result.
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_left;
  logic        m_done;

  always @(posedge clk) begin
    if (!resetn) begin
      m_hi <= '0; m_lo <= '0; m_left <= 0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (cancel) begin
        m_left <= 0;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= m_res[63:32];
          m_lo <= m_res[31:0];
          m_done <= 1'b1;
        end
      end else begin
        if (hi_we) m_hi <= wdata;
        if (lo_we) m_lo <= wdata;
        if (start) begin
          if (op[1] && src_b == 0) begin
            m_done <= 1'b1;
          end else begin
            m_res  <= ref_res(op, src_a, src_b);
            m_left <= op[1] ? 33 : MC;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      #2;
      chk("busy", 64'(busy), 64'(m_left != 0));
      chk("done", 64'(done), 64'(m_done));
      chk("stall", 64'(stall_req),
          64'((m_left != 0) & (start | hilo_rd | hi_we | lo_we)));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic idle_inputs();
    start = 0; op = 0; src_a = 0; src_b = 0; cancel = 0;
    hi_we = 0; lo_we = 0; wdata = 0; hilo_rd = 0;
  endtask

  // Present one start for one cycle; returns at cycle T+1 (+3).
  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    start = 1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 0;
    #3;
  endtask

  // Count cycles from T+1 until done is seen; bounded.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 60) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (!done) begin
      bad++;
      total++;
      $display("FAIL wait_done: no done within %0d cycles", n);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #600000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] sv_hi, sv_lo;
    logic seen;
    idle_inputs();
    resetn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1;
    chk_en = 1;
    #3;
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);

    // MULT -2*3
    issue(2'b00, 32'hFFFF_FFFE, 32'd3);
    chk("mult_busy1", 64'(busy), 64'h1);
    @(negedge clk); #3;
    chk("mult_busy2", 64'(busy), 64'h1);
    @(negedge clk); #3;
    chk("mult_done", 64'(done), 64'h1);
    chk("mult_res", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFFA);

    // MULTU
    issue(2'b01, 32'hFFFF_FFFF, 32'd2);
    wait_done(n);
    chk("multu_lat", 64'(n), 64'd3);
    chk("multu_res", {32'(hi), 32'(lo)}, 64'h0000_0001_FFFF_FFFE);

    // DIV -7/2
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    chk("div_lat", 64'(n), 64'd34);
    chk("div_res", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFFD);

    // DIVU 0x80000000/3
    issue(2'b11, 32'h8000_0000, 32'd3);
    wait_done(n);
    chk("divu_res", {32'(hi), 32'(lo)}, 64'h0000_0002_2AAA_AAAA);

    // DIV overflow case
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    chk("divov_res", {32'(hi), 32'(lo)}, 64'h0000_0000_8000_0000);

    // HI/LO access while dividing
    sv_hi = hi;
    issue(2'b11, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    hilo_rd = 1;
    #3;
    chk("stall_rd", 64'(stall_req), 64'h1);
    @(negedge clk);
    hilo_rd = 0; hi_we = 1; wdata = 32'hDEAD_BEEF;
    #3;
    chk("stall_we", 64'(stall_req), 64'h1);
    @(negedge clk);
    hi_we = 0;
    #3;
    chk("hi_held", 64'(hi), 64'(sv_hi));
    wait_done(n);
    chk("div100_res", {32'(hi), 32'(lo)}, 64'h0000_0002_0000_000E);
    @(negedge clk);
    hi_we = 1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 0;
    #3;
    chk("mthi", 64'(hi), 64'h1234);

    // Cancel mid-divide at T+10
    sv_hi = hi; sv_lo = lo;
    issue(2'b10, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    cancel = 1;
    @(negedge clk);
    cancel = 0;
    #3;
    chk("cxl_busy", 64'(busy), 64'h0);
    seen = 0;
    repeat (30) begin
      @(negedge clk); #3;
      if (done) seen = 1;
    end
    chk("cxl_nodone", 64'(seen), 64'h0);
    chk("cxl_hilo", {32'(hi), 32'(lo)}, {32'(sv_hi), 32'(sv_lo)});

    // Cancel in FIX (T+33)
    issue(2'b10, 32'd1000, 32'd3);
    repeat (32) @(negedge clk);
    cancel = 1;
    @(negedge clk);
    cancel = 0;
    #3;
    chk("fix_busy", 64'(busy), 64'h0);
    chk("fix_done", 64'(done), 64'h0);
    chk("fix_hilo", {32'(hi), 32'(lo)}, {32'(sv_hi), 32'(sv_lo)});

    // Divide by zero
    @(negedge clk);
    hi_we = 1; wdata = 32'hA;
    @(negedge clk);
    hi_we = 0; lo_we = 1; wdata = 32'hB;
    @(negedge clk);
    lo_we = 0;
    issue(2'b10, 32'd55, 32'd0);
    chk("dz_done", 64'(done), 64'h1);
    chk("dz_busy", 64'(busy), 64'h0);
    chk("dz_hilo", {32'(hi), 32'(lo)}, 64'h0000_000A_0000_000B);

    // Random traffic
    repeat (3000) begin
      @(negedge clk);
      resetn  = ($urandom_range(0, 299) != 0);
      start   = ($urandom_range(0, 3) == 0);
      op      = 2'($urandom_range(0, 3));
      src_a   = pick();
      src_b   = pick();
      cancel  = ($urandom_range(0, 39) == 0);
      hi_we   = ($urandom_range(0, 9) == 0);
      lo_we   = ($urandom_range(0, 9) == 0);
      wdata   = $urandom();
      hilo_rd = ($urandom_range(0, 4) == 0);
    end
    @(negedge clk);
    idle_inputs();
    resetn = 1;
    repeat (40) @(negedge clk);
    #4;
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
